// File: rtl/vga_pkg.sv
// Shared widths, FSM states and helpers for the VGA sync receiver.
// Used by vga_sync_meas and vga_sync_recover.
package vga_pkg;

  localparam int VIS_W   = 12;
  localparam int PORCH_W = 8;
  localparam int CNT_W   = 14;
  localparam int PHASE_W = 13;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  // |meas - exp_v| <= tol, without signed arithmetic
  function automatic logic in_tol(
    input logic [CNT_W-1:0] meas,
    input logic [CNT_W-1:0] exp_v,
    input logic [CNT_W-1:0] tol
  );
    logic [CNT_W-1:0] d;
    d = (meas >= exp_v) ? meas - exp_v : exp_v - meas;
    return d <= tol;
  endfunction

endpackage

// File: rtl/vga_sync_meas.sv
// Sync input stage: edge detect, period/width counters, timeout.
// Counters saturate so a dead input never wraps back into range.
module vga_sync_meas
  import vga_pkg::*;
(
  input  logic               P_CLK,
  input  logic               RST,
  input  logic               in_sync_i,
  input  logic [PHASE_W-1:0] total_i,
  output logic               fe_o,
  output logic [CNT_W-1:0]   per_o,
  output logic [CNT_W-1:0]   width_o,
  output logic               tmo_o
);

  logic             sync_q;
  logic             sync_qq;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] low_d;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_d;
  logic             fe;
  logic             re;

  assign fe = !sync_q && sync_qq;
  assign re = sync_q && !sync_qq;

  // Next-state for period, low-time and latched width
  always_comb begin
    per_d   = per_q;
    low_d   = low_q;
    width_d = width_q;
    if (fe) begin
      per_d = CNT_W'(1);
    end else if (per_q != '1) begin
      per_d = per_q + CNT_W'(1);
    end
    if (fe) begin
      low_d = CNT_W'(1);
    end else if (!sync_q && low_q != '1) begin
      low_d = low_q + CNT_W'(1);
    end
    if (re) begin
      width_d = low_q;
    end
  end

  // Input pipeline and measurement registers
  always_ff @(posedge P_CLK) begin
    if (!RST) begin
      sync_q  <= 1'b1;
      sync_qq <= 1'b1;
      per_q   <= '0;
      low_q   <= '0;
      width_q <= '0;
    end else begin
      sync_q  <= in_sync_i;
      sync_qq <= sync_q;
      per_q   <= per_d;
      low_q   <= low_d;
      width_q <= width_d;
    end
  end

  assign fe_o    = fe;
  assign per_o   = per_q;
  assign width_o = width_q;
  assign tmo_o   = !fe && (per_q >= {total_i, 1'b0});

endmodule

// File: rtl/vga_sync_recover.sv
// VGA sync receiver: locks a phase counter to incoming sync pulses.
// Optional VGA_RX_MEASURE_EN exposes last measured period/width.
module vga_sync_recover
  import vga_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
)(
  input  logic               P_CLK,
  input  logic               RST,
  input  logic               IN_SYNC,
  input  logic [VIS_W-1:0]   VIS,
  input  logic [PORCH_W-1:0] FRONT,
  input  logic [PORCH_W-1:0] SYNC,
  input  logic [PORCH_W-1:0] BACK,
  output logic [VIS_W-1:0]   POSITION,
  output logic               ACTIVE_ZONE,
  output logic               LOCKED,
  output logic               ERR
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [CNT_W-1:0]   MEAS_PERIOD,
  output logic [CNT_W-1:0]   MEAS_SYNC
`endif
);

  localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_COUNT);

  logic [PHASE_W-1:0] total;
  logic [PHASE_W-1:0] last_ph;
  logic [PHASE_W-1:0] sync_ph;
  logic               fe;
  logic               tmo;
  logic [CNT_W-1:0]   per;
  logic [CNT_W-1:0]   width;
  logic               pass;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         match_q;
  logic [3:0]         match_d;
  logic [3:0]         match_inc;
  logic               err_q;
  logic               err_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               az_q;
  logic               az_d;
  logic [VIS_W-1:0]   pos_q;
  logic [VIS_W-1:0]   pos_d;

  assign total = PHASE_W'(VIS) + PHASE_W'(BACK)
               + PHASE_W'(SYNC) + PHASE_W'(FRONT);
  assign last_ph = total - PHASE_W'(1);
  assign sync_ph = PHASE_W'(VIS) + PHASE_W'(BACK) + PHASE_W'(1);

  vga_sync_meas u_meas (
    .P_CLK     (P_CLK),
    .RST       (RST),
    .in_sync_i (IN_SYNC),
    .total_i   (total),
    .fe_o      (fe),
    .per_o     (per),
    .width_o   (width),
    .tmo_o     (tmo)
  );

  assign pass = in_tol(per, CNT_W'(total), TOL_V)
             && in_tol(width, CNT_W'(SYNC), TOL_V);
  assign match_inc = match_q + 4'd1;

  // Lock FSM: next state, match counter and error pulse
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        if (fe) begin
          state_d = S_ACQUIRE;
          match_d = '0;
        end
      end
      S_ACQUIRE: begin
        if (fe) begin
          if (pass) begin
            match_d = match_inc;
            if (match_inc >= LOCK_V) begin
              state_d = S_LOCKED;
            end
          end else begin
            match_d = '0;
            err_d   = 1'b1;
          end
        end else if (tmo) begin
          state_d = S_SEARCH;
          match_d = '0;
          err_d   = 1'b1;
        end
      end
      S_LOCKED: begin
        if (fe) begin
          if (!pass) begin
            state_d = S_ACQUIRE;
            match_d = '0;
            err_d   = 1'b1;
          end
        end else if (tmo) begin
          state_d = S_SEARCH;
          match_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_SEARCH;
        match_d = '0;
      end
    endcase
  end

  // Local phase: snapped to the sync slot on each falling edge
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    if (fe) begin
      phase_d = (sync_ph >= total) ? '0 : sync_ph;
    end else if (phase_q >= last_ph) begin
      phase_d = '0;
    end
  end

  // Regenerated active-zone and position
  always_comb begin
    az_d  = (state_q == S_LOCKED) && (phase_q < PHASE_W'(VIS));
    pos_d = az_d ? phase_q[VIS_W-1:0] : '0;
  end

  // FSM, phase and output registers
  always_ff @(posedge P_CLK) begin
    if (!RST) begin
      state_q <= S_SEARCH;
      match_q <= '0;
      err_q   <= 1'b0;
      phase_q <= '0;
      az_q    <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      az_q    <= az_d;
      pos_q   <= pos_d;
    end
  end

  assign LOCKED      = (state_q == S_LOCKED);
  assign ERR         = err_q;
  assign ACTIVE_ZONE = az_q;
  assign POSITION    = pos_q;

`ifdef VGA_RX_MEASURE_EN
  logic [CNT_W-1:0] mper_q;
  logic [CNT_W-1:0] msync_q;

  // Hold the last measurement for mode detection
  always_ff @(posedge P_CLK) begin
    if (!RST) begin
      mper_q  <= '0;
      msync_q <= '0;
    end else if (fe) begin
      mper_q  <= per;
      msync_q <= width;
    end
  end

  assign MEAS_PERIOD = mper_q;
  assign MEAS_SYNC   = msync_q;
`endif

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover (TOL=0 and TOL=1 instances).
// Expected events are queued per period and checked at their cycle.
module tb_vga_sync_recover;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_sync = 1'b1;
  logic [11:0] vis = 12'd640;
  logic [7:0]  front = 8'd48;
  logic [7:0]  sync_w = 8'd96;
  logic [7:0]  back = 8'd16;
  logic [11:0] pos0, pos1;
  logic        az0, az1, lk0, lk1, err0, err1;
`ifdef VGA_RX_MEASURE_EN
  logic [13:0] mp0, ms0, mp1, ms1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int    cyc;
    int    d;
    int    sel;
    int    exp;
    string tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  logic [31:0] obs_m;

  vga_sync_recover #(.LOCK_COUNT(4), .TOL(0)) dut0 (
    .P_CLK(clk), .RST(rst_n), .IN_SYNC(in_sync),
    .VIS(vis), .FRONT(front), .SYNC(sync_w), .BACK(back),
    .POSITION(pos0), .ACTIVE_ZONE(az0),
    .LOCKED(lk0), .ERR(err0)
`ifdef VGA_RX_MEASURE_EN
    , .MEAS_PERIOD(mp0), .MEAS_SYNC(ms0)
`endif
  );

  vga_sync_recover #(.LOCK_COUNT(4), .TOL(1)) dut1 (
    .P_CLK(clk), .RST(rst_n), .IN_SYNC(in_sync),
    .VIS(vis), .FRONT(front), .SYNC(sync_w), .BACK(back),
    .POSITION(pos1), .ACTIVE_ZONE(az1),
    .LOCKED(lk1), .ERR(err1)
`ifdef VGA_RX_MEASURE_EN
    , .MEAS_PERIOD(mp1), .MEAS_SYNC(ms1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int d, int sel);
    case (sel)
      0: return 32'(d != 0 ? err1 : err0);
      1: return 32'(d != 0 ? lk1 : lk0);
      2: return 32'(d != 0 ? az1 : az0);
      3: return 32'(d != 0 ? pos1 : pos0);
      default: return d != 0 ? 32'(dut1.state_q)
                             : 32'(dut0.state_q);
    endcase
  endfunction

  task automatic push(int c, int d, int sel, int e, string tag);
    exp_t x;
    x.cyc = c; x.d = d; x.sel = sel; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sync period; expectations are for the fe registered in it
  task automatic period(
    input int per, input int low,
    input int e_err0, input int e_lk0, input int e_st0,
    input int e_err1, input int e_lk1,
    input bit az, input string tag, output int n
  );
    n = cyc;
    if (e_err0 >= 0) push(n + 2, 0, 0, e_err0, {tag, ".err0"});
    if (e_lk0 >= 0)  push(n + 2, 0, 1, e_lk0, {tag, ".lk0"});
    if (e_st0 >= 0)  push(n + 2, 0, 4, e_st0, {tag, ".st0"});
    if (e_err1 >= 0) push(n + 2, 1, 0, e_err1, {tag, ".err1"});
    if (e_lk1 >= 0)  push(n + 2, 1, 1, e_lk1, {tag, ".lk1"});
    if (e_err0 == 1) push(n + 3, 0, 0, 0, {tag, ".errw"});
    if (az) begin
      push(n + 145, 0, 2, 0, {tag, ".az_pre"});
      push(n + 146, 0, 2, 1, {tag, ".az_rise"});
      push(n + 146, 0, 3, 0, {tag, ".pos0"});
      push(n + 465, 0, 3, 319, {tag, ".pos319"});
      push(n + 785, 0, 2, 1, {tag, ".az_last"});
      push(n + 785, 0, 3, 639, {tag, ".pos639"});
      push(n + 786, 0, 2, 0, {tag, ".az_fall"});
      push(n + 786, 0, 3, 0, {tag, ".pos_off"});
    end
    for (int i = 0; i < per; i++) begin
      in_sync = (i < low) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop and compare every expectation due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_m = sb.pop_front();
      obs_m = observe(e_m.d, e_m.sel);
      checks++;
      assert (e_m.cyc == cyc && obs_m === 32'(e_m.exp)) else begin
        failures++;
        $error("FAIL %s due=%0d at=%0d observed=%0d expected=%0d",
               e_m.tag, e_m.cyc, cyc, obs_m, e_m.exp);
      end
    end
  end

  initial begin
    int n;
    int n18;
    int acq;
    int lkd;
    acq = int'(S_ACQUIRE);
    lkd = int'(S_LOCKED);

    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_sync = ~in_sync;
      @(negedge clk);
      chk("rst.lk", 32'(lk0), 0);
      chk("rst.az", 32'(az0), 0);
      chk("rst.pos", 32'(pos0), 0);
      chk("rst.err", 32'(err0), 0);
      chk("rst.st", 32'(dut0.state_q), 32'(S_SEARCH));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_sync = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("idle.st", 32'(dut0.state_q), 32'(S_SEARCH));
    chk("idle.err", 32'(err0), 0);

    period(800, 96, 0, 0, acq, 0, 0, 0, "p1", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "p2", n);
`ifdef VGA_RX_MEASURE_EN
    chk("meas.per", 32'(mp0), 800);
    chk("meas.sync", 32'(ms0), 96);
`endif
    period(800, 96, 0, 0, acq, 0, 0, 0, "p3", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "p4", n);
    period(800, 96, 0, 1, lkd, 0, 1, 1, "p5", n);
    period(800, 96, 0, 1, lkd, 0, 1, 1, "p6", n);

    period(801, 96, 0, 1, lkd, 0, 1, 0, "p7", n);
    period(800, 96, 1, 0, acq, 0, 1, 0, "p8", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p9", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p10", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p11", n);
    period(800, 96, 0, 1, lkd, 0, 1, 0, "p12", n);

    period(800, 95, 0, 1, lkd, 0, 1, 0, "p13", n);
    period(800, 96, 1, 0, acq, 0, 1, 0, "p14", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p15", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p16", n);
    period(800, 96, 0, 0, acq, 0, 1, 0, "p17", n);
    period(800, 96, 0, 1, lkd, 0, 1, 0, "p18", n18);

    push(n18 + 1601, 0, 0, 0, "los.err_pre");
    push(n18 + 1601, 0, 1, 1, "los.lk_pre");
    push(n18 + 1602, 0, 0, 1, "los.err");
    push(n18 + 1602, 0, 1, 0, "los.lk");
    push(n18 + 1602, 0, 4, int'(S_SEARCH), "los.st");
    push(n18 + 1602, 1, 0, 1, "los.err1");
    push(n18 + 1602, 1, 1, 0, "los.lk1");
    push(n18 + 1603, 0, 0, 0, "los.errw");
    repeat (1700) begin
      @(posedge clk);
      #1;
    end

    period(800, 96, 0, 0, acq, 0, 0, 0, "pa", n);
    period(1600, 96, 0, 0, acq, 0, 0, 0, "pb", n);
    period(800, 96, 1, 0, acq, 1, 0, 0, "pc", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "pd", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "pe", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "pf", n);
    period(800, 96, 0, 1, lkd, 0, 1, 0, "pg", n);

    period(400, 96, 0, 1, lkd, 0, 1, 0, "ph", n);
    @(negedge clk);
    chk("mid.az", 32'(az0), 1);
    chk("mid.pos", 32'(pos0), 254);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid.rst.lk", 32'(lk0), 0);
    chk("mid.rst.az", 32'(az0), 0);
    chk("mid.rst.pos", 32'(pos0), 0);
    chk("mid.rst.lk1", 32'(lk1), 0);
    chk("mid.rst.st", 32'(dut0.state_q), 32'(S_SEARCH));
    @(posedge clk);
    #1;

    period(800, 96, 0, 0, acq, 0, 0, 0, "r1", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "r2", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "r3", n);
    period(800, 96, 0, 0, acq, 0, 0, 0, "r4", n);
    period(800, 96, 0, 1, lkd, 0, 1, 1, "r5", n);

    repeat (10) @(posedge clk);
    chk("sb.drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_recover.md
# vga_sync_recover

Receive-side counterpart of the VGA sync timing generator. It watches an incoming active-low sync stream on one axis, checks it against the configured VIS/BACK/SYNC/FRONT timing and locks a local phase counter to it. Once locked it regenerates POSITION and ACTIVE_ZONE in the same form the generator produces. One instance serves the horizontal axis and a second serves the vertical axis, sitting between an external video input and the pixel capture logic.

## Interface
- LOCK_COUNT, 4: number of consecutive qualifying periods required before LOCKED asserts (1..15).
- TOL, 0: allowed ± deviation in cycles for both the measured period and the measured sync width.
- P_CLK  in  1  pixel clock; all logic is on its rising edge.
- RST  in  1  synchronous, active-low reset.
- IN_SYNC  in  1  incoming sync, active-low, synchronous to P_CLK.
- VIS  in  12  expected visible cycles.
- FRONT, SYNC, BACK  in  8 each  expected porch and sync widths.
- POSITION  out  12  recovered position inside the active zone, otherwise 0.
- ACTIVE_ZONE  out  1  high while the recovered phase is below VIS and the block is locked.
- LOCKED  out  1  timing lock status.
- ERR  out  1  one-cycle pulse on a mismatch or a timeout.

## Operation
- Period ordering: VIS, BACK, SYNC, FRONT. TOTAL = VIS+BACK+SYNC+FRONT, computed in 13 bits.
- Timing inputs are static while LOCKED. A change is seen as a mismatch at the next compare.
- Input stage: sync_q <= IN_SYNC, then sync_qq <= sync_q. A falling edge (fe) is sync_q==0 && sync_qq==1.
- Measurement runs in 14-bit counters:
  - per_cnt counts cycles between fe events and saturates.
  - low_cnt counts sync_q-low cycles since the last fe and is latched at the rising edge.
- Compare at each fe (except the first):
  - The check passes when |per_cnt−TOTAL| ≤ TOL and |low_width−SYNC| ≤ TOL.
  - low_width is taken from the pulse preceding this fe.
- PHASE counts modulo TOTAL and is 13 bits wide.
  - On every fe: PHASE <= VIS+BACK+1, so the first sampled-low cycle is phase VIS+BACK.
  - Otherwise PHASE <= PHASE+1, wrapping at TOTAL−1 to 0.
- FSM:
  - SEARCH: wait for the first fe, clear match_cnt, go to ACQUIRE.
  - ACQUIRE:
    - Compare pass: match_cnt++.
    - Compare fail: match_cnt=0 and ERR pulse.
    - match_cnt reaching LOCK_COUNT: go to LOCKED.
  - LOCKED: a compare fail pulses ERR, drops LOCKED and returns to ACQUIRE with match_cnt=0.
  - Any state except SEARCH: no fe within 2·TOTAL cycles of the last fe pulses ERR and returns to SEARCH.
- Outputs, registered:
  - ACTIVE_ZONE <= LOCKED && PHASE<VIS.
  - POSITION <= ACTIVE_ZONE-condition ? PHASE : 0.

## Timing
- Reset values:
  - POSITION=0, ACTIVE_ZONE=0, LOCKED=0, ERR=0.
  - sync_q=sync_qq=1, state SEARCH, counters 0, PHASE 0.
- Latency:
  - The clock edge k that first samples IN_SYNC low gives fe in cycle k+1.
  - PHASE is loaded at edge k+1.
  - ACTIVE_ZONE/POSITION reflect PHASE one edge later.
- LOCKED rises on the edge that registers the LOCK_COUNT-th consecutive pass. It falls on the edge that registers the failing compare or the timeout.
- ERR is exactly one cycle wide. Back-to-back failures produce separate pulses.
- If fe and timeout occur in the same cycle, fe wins and no timeout is raised.
- A pulse still low at the period end (SYNC≥TOTAL) fails as a width mismatch.
- RST low in any state clears everything on the next edge. No partial lock survives.

## Configuration
- VGA_RX_MEASURE_EN defined:
  - Adds outputs MEAS_PERIOD[13:0] and MEAS_SYNC[13:0], holding the last measured period and sync width. Both update at each fe and reset to 0.
  - Used for auto-detecting the input mode.
- Undefined: these ports and their holding registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package vga_pkg:
  - Width constants VIS_W=12, PORCH_W=8, CNT_W=14, PHASE_W=13.
  - The FSM state enum (SEARCH, ACQUIRE, LOCKED).
- Sub-module vga_sync_meas holds the input registers, fe detection, per_cnt, low_cnt, width latch and timeout flag. The top holds the FSM, PHASE and output registers.

## Test plan
- Reset: RST low for 5 cycles with IN_SYNC toggling -> all outputs 0, state SEARCH, no ERR.
- Clean lock, VIS=640 BACK=16 SYNC=96 FRONT=48 (TOTAL=800), LOCK_COUNT=4, IN_SYNC low 96 of every 800 cycles ->
  - LOCKED rises at the 5th fe.
  - ACTIVE_ZONE rises 145 edges after IN_SYNC is first sampled low and stays high 640 cycles.
  - POSITION steps 0..639.
- Period jitter after lock: one period of 801, TOL=0 -> single ERR pulse, LOCKED low, ACQUIRE. Relock after 4 clean periods.
- Sync width 95 cycles -> with TOL=0, ERR and lock loss. With TOL=1, LOCKED stays high.
- Loss of signal: IN_SYNC held high after lock -> ERR pulse and LOCKED low exactly 1600 cycles after the last fe, state SEARCH.
- Reset mid-lock: RST low for 1 cycle while LOCKED -> LOCKED, ACTIVE_ZONE and POSITION are 0 next cycle. Reacquires after 5 fe with clean input.
